// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial-data receiver with a show-ahead stereo-pair FIFO.
//
// Shares the bit-slot enable and 64-slot frame position with the I2S
// transmitter. The serial data is deserialised MSB-first into a 16-bit
// shifter. The left word is latched at slot 18 and the right word at
// slot 50, and each complete {left, right} pair is queued for the
// downstream DSP.
//
// Ports:
//   ck          system clock, rising edge
//   rst         synchronous active-high reset
//   en          one-cycle pulse per I2S bit slot
//   frame_posn  slot index 0..63, meaningful only while en=1
//   sd          serial data, already synchronised to ck
//   ready       consumer accepts the head pair when valid & ready
//   left/right  head-of-FIFO samples, forced to zero while empty
//   valid       FIFO non-empty
//   level       number of pairs held, 0..2^DEPTH_LOG2
//   overrun     sticky flag: a pair was dropped on a full FIFO
module i2s_rx #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  en,
    input  logic [5:0]            frame_posn,
    input  logic                  sd,
    input  logic                  ready,
    output logic [15:0]           left,
    output logic [15:0]           right,
    output logic                  valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_LVL  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [15:0]           r_shift;
    logic [15:0]           r_hold_l;
    logic                  r_armed;
    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overrun;

    logic w_cap_l;
    logic w_push;
    logic w_full;
    logic w_nonempty;
    logic w_pop;
    logic w_wr;

    // Slot 18 follows the last left bit (slot 17). Slot 50 follows the last
    // right bit (slot 49). The shifter is used at its pre-edge value.
    assign w_cap_l    = en && (frame_posn == 6'd18);
    assign w_push     = en && (frame_posn == 6'd50) && r_armed;
    assign w_full     = (r_level == FULL_LVL);
    assign w_nonempty = (r_level != '0);
    assign w_pop      = w_nonempty && ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr       = w_push && (!w_full || w_pop);

    always_ff @(posedge ck) begin
        if (rst) begin
            r_shift   <= '0;
            r_hold_l  <= '0;
            r_armed   <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (en) begin
                r_shift <= {r_shift[14:0], sd};
            end
            if (w_cap_l) begin
                r_hold_l <= r_shift;
                r_armed  <= 1'b1;
            end
            if (w_push) begin
                r_armed <= 1'b0;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + ONE_LVL;
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - ONE_LVL;
            end
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Storage is not reset; empty entries are masked at the outputs.
    always_ff @(posedge ck) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {r_hold_l, r_shift};
        end
    end

    assign valid   = w_nonempty;
    assign level   = r_level;
    assign overrun = r_overrun;
    assign left    = w_nonempty ? r_mem[r_rptr][31:16] : 16'd0;
    assign right   = w_nonempty ? r_mem[r_rptr][15:0]  : 16'd0;

endmodule

// File: tb/tb_i2s_rx.sv
// Testbench for i2s_rx: a transmitter model drives sd slot by slot. A
// queue-level reference model tracks which stereo pairs must be held, and a
// monitor compares the DUT outputs against that model on every falling edge.
module tb_i2s_rx;

    logic        ck = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [5:0]  frame_posn = 6'd0;
    logic        sd = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] left;
    logic [15:0] right;
    logic        valid;
    logic [2:0]  level;
    logic        overrun;

    i2s_rx #(.DEPTH_LOG2(2)) dut (
        .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn), .sd(sd),
        .ready(ready), .left(left), .right(right), .valid(valid),
        .level(level), .overrun(overrun)
    );

    always #5 ck = ~ck;

    int nchk = 0;
    int nerr = 0;

    // Reference model state: the pairs that must be in the FIFO, oldest first.
    logic [31:0] mq [$];
    logic        m_ovr = 1'b0;
    logic        m_armed = 1'b0;
    logic [15:0] m_hold = 16'd0;
    logic [15:0] cur_l = 16'd0;
    logic [15:0] cur_r = 16'd0;

    logic [31:0] popped [$];
    int          npop = 0;
    int          nvalid = 0;
    int          maxlvl = 0;
    bit          mon_on = 1'b0;
    int          mode = 0;
    int          vcnt = 0;
    bit          oneshot = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (i < popped.size()) return popped[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Reference model: a frame is delivered when its slot-18 capture and
    // slot-50 push both occur out of reset; a full FIFO drops the pair unless
    // a pop frees a slot in the same cycle.
    initial begin : model
        bit pop;
        bit push;
        bit full;
        forever begin
            @(posedge ck);
            if (rst) begin
                mq.delete();
                m_ovr = 1'b0;
                m_armed = 1'b0;
                m_hold = 16'd0;
            end else begin
                full = (mq.size() == 4);
                pop  = (mq.size() != 0) && ready;
                push = en && (frame_posn == 6'd50) && m_armed;
                if (en && frame_posn == 6'd18) begin
                    m_hold = cur_l;
                    m_armed = 1'b1;
                end
                if (push) m_armed = 1'b0;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    if (full && !pop) m_ovr = 1'b1;
                    else mq.push_back({m_hold, cur_r});
                end
            end
        end
    end

    // Monitor: compare every output against the model away from the edge.
    initial begin : monitor
        logic [31:0] exp_head;
        logic [2:0]  exp_lvl;
        logic        exp_v;
        forever begin
            @(negedge ck);
            if (mon_on) begin
                exp_v    = (mq.size() != 0);
                exp_lvl  = 3'(mq.size());
                exp_head = exp_v ? mq[0] : 32'd0;
                nchk++;
                if ({valid, level, overrun, left, right} !== {exp_v, exp_lvl, m_ovr, exp_head}) begin
                    nerr++;
                    $display("FAIL state@%0t: got v=%b lvl=%0d ovr=%b l=%h r=%h, expected v=%b lvl=%0d ovr=%b l=%h r=%h",
                             $time, valid, level, overrun, left, right,
                             exp_v, exp_lvl, m_ovr, exp_head[31:16], exp_head[15:0]);
                end
                if (valid && ready) begin
                    npop++;
                    popped.push_back({left, right});
                end
                if (valid) nvalid++;
                if (int'(level) > maxlvl) maxlvl = int'(level);
            end
        end
    end

    // One ck cycle of stimulus; ready is chosen by the current consumer mode.
    task automatic cyc(input logic en_v, input logic [5:0] p, input logic sd_v, input logic rst_v);
        en = en_v;
        frame_posn = p;
        sd = sd_v;
        rst = rst_v;
        case (mode)
            0: ready = 1'b1;
            1: ready = 1'b0;
            2: ready = 1'($urandom_range(0, 1));
            3: begin
                if (valid) vcnt++;
                else vcnt = 0;
                ready = (vcnt >= 3);
                if (ready) vcnt = 0;
            end
            4: begin
                ready = oneshot && valid;
                if (ready) oneshot = 1'b0;
            end
            5: ready = en_v && (p == 6'd50);
            default: ready = 1'b0;
        endcase
        @(posedge ck);
        #1;
    endtask

    // One bit slot: the en cycle carrying the transmitter's bit, then three
    // idle cycles with random frame_posn (en=0 must ignore it).
    task automatic slot(input int p, input logic [15:0] l, input logic [15:0] r,
                        input logic rst_v, input bit pulse);
        logic b;
        if (p >= 2 && p <= 17) b = l[17-p];
        else if (p >= 34 && p <= 49) b = r[49-p];
        else b = 1'($urandom);
        cyc(1'b1, 6'(p), b, rst_v);
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, 6'($urandom_range(0, 63)), 1'($urandom), rst_v | (pulse && g == 0));
            if (pulse && g == 0) begin
                chk("midrst_valid", 32'(valid), 32'd0);
                chk("midrst_level", 32'(level), 32'd0);
                chk("midrst_overrun", 32'(overrun), 32'd0);
                chk("midrst_lr", {left, right}, 32'd0);
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                             input int rst_lo, input int rst_hi, input int pulse_slot);
        cur_l = l;
        cur_r = r;
        for (int p = 0; p < 64; p++) begin
            slot(p, l, r, (p >= rst_lo && p <= rst_hi), (p == pulse_slot));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'($urandom_range(0, 63)), 1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 6'd0, 1'b0, 1'b1);
        cyc(1'b0, 6'd0, 1'b0, 1'b1);
        vcnt = 0;
    endtask

    logic [31:0] wrap_exp [10];

    initial begin : stim
        int lv_exp [5] = '{1, 2, 3, 4, 4};
        logic [15:0] n16;

        // Reset state
        do_reset();
        mon_on = 1'b1;
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_left", 32'(left), 32'd0);
        chk("reset_right", 32'(right), 32'd0);

        // Loopback: one pair per frame, valid high one cycle each
        mode = 0; npop = 0; nvalid = 0; popped.delete();
        for (int f = 0; f < 3; f++) run_frame(16'hA5C3, 16'h1234, -1, -1, -1);
        idle(8);
        chk("loop_pops", npop, 3);
        chk("loop_valid_cycles", nvalid, 3);
        chk("loop_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) chk("loop_pair", pop_at(i), 32'hA5C3_1234);

        // Partial frame: reset held until slot 20
        npop = 0; popped.delete();
        run_frame(16'h8001, 16'h7FFE, 0, 19, -1);
        chk("partial_nopush", npop, 0);
        run_frame(16'h8001, 16'h7FFE, -1, -1, -1);
        idle(8);
        chk("partial_pops", npop, 1);
        chk("partial_pair", pop_at(0), 32'h8001_7FFE);

        // Fill and overflow
        do_reset();
        mode = 1;
        for (int n = 1; n <= 5; n++) begin
            n16 = 16'(n);
            run_frame(n16, ~n16, -1, -1, -1);
            chk($sformatf("fill_level_%0d", n), 32'(level), 32'(lv_exp[n-1]));
        end
        chk("fill_overrun", 32'(overrun), 32'd1);
        mode = 0; popped.delete();
        idle(10);
        chk("drain_count", popped.size(), 4);
        for (int n = 1; n <= 4; n++) begin
            n16 = 16'(n);
            chk($sformatf("drain_pair_%0d", n), pop_at(n-1), {n16, ~n16});
        end
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_lr", {left, right}, 32'd0);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        mode = 1; popped.delete();
        for (int n = 1; n <= 4; n++) begin
            n16 = 16'(n);
            run_frame(n16, ~n16, -1, -1, -1);
        end
        mode = 5;
        run_frame(16'd5, ~16'd5, -1, -1, -1);
        chk("simul_level", 32'(level), 32'd4);
        chk("simul_overrun", 32'(overrun), 32'd0);
        mode = 0;
        idle(10);
        for (int n = 1; n <= 5; n++) begin
            n16 = 16'(n);
            chk($sformatf("simul_pair_%0d", n), pop_at(n-1), {n16, ~n16});
        end

        // Pointer wrap with delayed pops
        do_reset();
        mode = 3; maxlvl = 0; popped.delete();
        for (int f = 0; f < 10; f++) begin
            wrap_exp[f] = $urandom;
            run_frame(wrap_exp[f][31:16], wrap_exp[f][15:0], -1, -1, -1);
        end
        idle(20);
        chk("wrap_count", popped.size(), 10);
        for (int f = 0; f < 10; f++) chk($sformatf("wrap_pair_%0d", f), pop_at(f), wrap_exp[f]);
        chk("wrap_maxlevel_le1", 32'(maxlvl <= 1), 32'd1);

        // Mid-stream reset with level 3 and overrun set
        do_reset();
        mode = 1;
        for (int n = 1; n <= 5; n++) begin
            n16 = 16'(n);
            run_frame(n16, ~n16, -1, -1, -1);
        end
        mode = 4; oneshot = 1'b1;
        idle(6);
        mode = 1;
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_overrun", 32'(overrun), 32'd1);
        run_frame(16'h1111, 16'h2222, -1, -1, 25);
        chk("post_rst_nopush", 32'(level), 32'd0);
        run_frame(16'h3333, 16'h4444, -1, -1, -1);
        chk("post_rst_push", 32'(level), 32'd1);
        mode = 0; popped.delete();
        idle(5);
        chk("post_rst_pair", pop_at(0), 32'h3333_4444);

        // Random data with a random consumer
        do_reset();
        mode = 2;
        for (int f = 0; f < 6; f++) run_frame(16'($urandom), 16'($urandom), -1, -1, -1);
        mode = 0;
        idle(10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
